score_digit_fetcher: RTL

Sequencer that shares the digit font ROM (digits 0–9, 16 rows × 8 px per glyph, one-cycle registered-address read latency) between scanlines and the pixel path. At the start of each horizontal blank inside the score text band, it requests the ROM through a req/gnt handshake and fetches one glyph row per displayed digit into a line buffer. During active video it serializes that buffer into a 1-bit `text_on` overlay for the colour mixer. It sits between the VGA sync generator, the score registers and the ROM arbiter.

---
 rtl/pong_pkg.sv | 19 +
 rtl/glyph_line_buf.sv | 53 +++++
 rtl/score_digit_fetcher.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared glyph geometry, BCD width and fetch FSM states
package pong_pkg;

    localparam int GLYPH_W = 8;
    localparam int GLYPH_H = 16;
    localparam int BCD_W   = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_FETCH,
        ST_CAPT
    } fetch_state_e;

    function automatic logic glyph_valid(input logic [BCD_W-1:0] code);
        return code <= 4'd9;
    endfunction

endpackage

// File: rtl/glyph_line_buf.sv
// rtl/glyph_line_buf.sv - one glyph row per digit, with clear and a pixel-select read mux
module glyph_line_buf
    import pong_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int IW         = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               clr,
    input  logic               we,
    input  logic [IW-1:0]      waddr,
    input  logic [GLYPH_W-1:0] wdata,
    input  logic [6:0]         rsel,
    input  logic [2:0]         rbit,
    output logic               rdata
);

    logic [GLYPH_W-1:0] line_q [NUM_DIGITS];
    logic [GLYPH_W-1:0] line_d [NUM_DIGITS];

    always_comb begin
        for (int k = 0; k < NUM_DIGITS; k++) begin
            line_d[k] = line_q[k];
            if (clr) begin
                line_d[k] = '0;
            end else if (we && waddr == IW'(k)) begin
                line_d[k] = wdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (!reset_n) begin
                line_q[k] <= '0;
            end else begin
                line_q[k] <= line_d[k];
            end
        end
    end

    // Columns past the last digit read as blank rather than aliasing.
    always_comb begin
        rdata = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (rsel == 7'(k)) begin
                rdata = line_q[k][rbit];
            end
        end
    end

endmodule

// File: rtl/score_digit_fetcher.sv
// rtl/score_digit_fetcher.sv - fetches one glyph row per score digit in hblank and serializes it as text_on
module score_digit_fetcher
    import pong_pkg::*;
#(
    parameter int         NUM_DIGITS = 4,
    parameter logic [9:0] X_START    = 10'd288,
    parameter logic [9:0] Y_START    = 10'd16
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          line_start,
    input  logic [9:0]                    y,
    input  logic [9:0]                    x,
    input  logic                          video_on,
    input  logic [BCD_W*NUM_DIGITS-1:0]   digits,
    output logic                          rom_req,
    input  logic                          rom_gnt,
    output logic [7:0]                    rom_addr,
    input  logic [7:0]                    rom_data,
    output logic                          text_on,
    output logic                          busy
);

    localparam int               IW       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IW-1:0]    LAST_IDX = IW'(NUM_DIGITS - 1);
    localparam logic [10:0]      X_END    = {1'b0, X_START} + 11'(GLYPH_W * NUM_DIGITS);
    localparam logic [10:0]      Y_END    = {1'b0, Y_START} + 11'(GLYPH_H);

    fetch_state_e                state_q, state_d;
    logic [IW-1:0]               idx_q, idx_d;
    logic [3:0]                  row_q, row_d;
    logic [BCD_W*NUM_DIGITS-1:0] snap_q, snap_d;
    logic                        text_on_q, text_on_d;

    logic                        in_band;
    logic [3:0]                  row_in;
    logic [IW-1:0]               cap_idx;
    logic [BCD_W-1:0]            code_cur;
    logic [BCD_W-1:0]            code_prev;
    logic                        buf_clr;
    logic                        buf_we;
    logic [GLYPH_W-1:0]          buf_wdata;
    logic [9:0]                  dx;
    logic                        hit;
    logic                        pix_bit;

    assign in_band = ({1'b0, y} >= {1'b0, Y_START}) && ({1'b0, y} < Y_END);
    assign row_in  = y[3:0] - Y_START[3:0];

    // The byte arriving now belongs to the address issued one cycle earlier.
    assign cap_idx   = (state_q == ST_CAPT) ? LAST_IDX : idx_q - IW'(1);
    assign code_cur  = snap_q[BCD_W*idx_q +: BCD_W];
    assign code_prev = snap_q[BCD_W*cap_idx +: BCD_W];
    assign buf_wdata = glyph_valid(code_prev) ? rom_data : '0;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        row_d    = row_q;
        snap_d   = snap_q;
        rom_req  = 1'b0;
        rom_addr = '0;
        busy     = 1'b1;
        buf_clr  = 1'b0;
        buf_we   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                busy = 1'b0;
                if (line_start) begin
                    if (in_band) begin
                        row_d = row_in;
                        idx_d = '0;
                        // Leftmost digit is the most significant nibble, so 16'h1234 reads "1234".
                        for (int k = 0; k < NUM_DIGITS; k++) begin
                            snap_d[BCD_W*k +: BCD_W] = digits[BCD_W*(NUM_DIGITS-1-k) +: BCD_W];
                        end
                        state_d = ST_REQ;
                    end else begin
                        buf_clr = 1'b1;
                    end
                end
            end
            ST_REQ: begin
                rom_req = 1'b1;
                if (rom_gnt) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                rom_req  = 1'b1;
                rom_addr = {code_cur, row_q};
                buf_we   = (idx_q != '0);
                if (idx_q == LAST_IDX) begin
                    state_d = ST_CAPT;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            ST_CAPT: begin
                buf_we  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    glyph_line_buf #(
        .NUM_DIGITS (NUM_DIGITS),
        .IW         (IW)
    ) u_line_buf (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (buf_clr),
        .we      (buf_we),
        .waddr   (cap_idx),
        .wdata   (buf_wdata),
        .rsel    (dx[9:3]),
        .rbit    (~dx[2:0]),
        .rdata   (pix_bit)
    );

    assign dx        = x - X_START;
    assign hit       = video_on && ({1'b0, x} >= {1'b0, X_START}) && ({1'b0, x} < X_END);
    assign text_on_d = hit & pix_bit;
    assign text_on   = text_on_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            row_q     <= '0;
            snap_q    <= '0;
            text_on_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            row_q     <= row_d;
            snap_q    <= snap_d;
            text_on_q <= text_on_d;
        end
    end

endmodule
